// File: rtl/keypad_pkg.sv
// Shared grid geometry, key codes, state/direction types and cell helpers
// for the keypad cursor controller.
package keypad_pkg;

    localparam int GRID_COLS = 5;
    localparam int GRID_ROWS = 3;
    localparam int X_ORIGIN  = 60;
    localparam int Y_ORIGIN  = 160;
    localparam int X_PITCH   = 90;
    localparam int Y_PITCH   = 100;

    localparam logic [2:0] LAST_COL  = 3'(GRID_COLS - 1);
    localparam logic [1:0] LAST_ROW  = 2'(GRID_ROWS - 1);
    localparam logic [2:0] RESET_COL = 3'd2;
    localparam logic [1:0] RESET_ROW = 2'd1;

    localparam logic [3:0] KEY_ADD   = 4'hA;
    localparam logic [3:0] KEY_SUB   = 4'hB;
    localparam logic [3:0] KEY_MUL   = 4'hC;
    localparam logic [3:0] KEY_DIV   = 4'hD;
    localparam logic [3:0] KEY_EQ    = 4'hE;
    localparam logic [3:0] RESET_KEY = 4'h5;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_SEL   = 4;
    localparam int NUM_BTNS  = 5;

    typedef enum logic [1:0] {
        SEL_IDLE     = 2'd0,
        SEL_VALID    = 2'd1,
        SEL_WAIT_REL = 2'd2
    } sel_state_e;

    typedef enum logic [1:0] {
        MOVE_UP    = 2'd0,
        MOVE_DOWN  = 2'd1,
        MOVE_LEFT  = 2'd2,
        MOVE_RIGHT = 2'd3
    } move_dir_e;

    function automatic logic [3:0] key_at(input logic [2:0] col, input logic [1:0] row);
        logic [3:0] code;
        code = 4'h0;
        case (row)
            2'd0: case (col)
                3'd0: code = 4'h7;
                3'd1: code = 4'h8;
                3'd2: code = 4'h9;
                3'd3: code = KEY_ADD;
                3'd4: code = KEY_DIV;
                default: code = 4'h0;
            endcase
            2'd1: case (col)
                3'd0: code = 4'h4;
                3'd1: code = 4'h5;
                3'd2: code = 4'h6;
                3'd3: code = KEY_SUB;
                3'd4: code = KEY_MUL;
                default: code = 4'h0;
            endcase
            2'd2: case (col)
                3'd0: code = 4'h1;
                3'd1: code = 4'h2;
                3'd2: code = 4'h3;
                3'd3: code = 4'h0;
                3'd4: code = KEY_EQ;
                default: code = 4'h0;
            endcase
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [2:0] next_col(input logic [2:0] col, input move_dir_e dir,
                                            input logic wrap);
        logic [2:0] col_n;
        col_n = col;
        if (dir == MOVE_RIGHT)
            col_n = (col == LAST_COL) ? (wrap ? 3'd0 : LAST_COL) : col + 3'd1;
        else if (dir == MOVE_LEFT)
            col_n = (col == 3'd0) ? (wrap ? LAST_COL : 3'd0) : col - 3'd1;
        return col_n;
    endfunction

    function automatic logic [1:0] next_row(input logic [1:0] row, input move_dir_e dir,
                                            input logic wrap);
        logic [1:0] row_n;
        row_n = row;
        if (dir == MOVE_DOWN)
            row_n = (row == LAST_ROW) ? (wrap ? 2'd0 : LAST_ROW) : row + 2'd1;
        else if (dir == MOVE_UP)
            row_n = (row == 2'd0) ? (wrap ? LAST_ROW : 2'd0) : row - 2'd1;
        return row_n;
    endfunction

    function automatic logic [9:0] pixel_x(input logic [2:0] col);
        return 10'(X_ORIGIN + X_PITCH * int'(col));
    endfunction

    function automatic logic [9:0] pixel_y(input logic [1:0] row);
        return 10'(Y_ORIGIN + Y_PITCH * int'(row));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-count debouncer and one-cycle rising-edge
// pulse for a single raw pushbutton.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The count only runs while the synchronized input disagrees with the
    // accepted level, so any sample that matches the old level restarts it.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/keypad_cursor_ctrl.sv
// On-screen keypad: debounced buttons move a cursor over a 5x3 key grid once
// per frame, and a select handshake reports the highlighted key.
module keypad_cursor_ctrl
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WRAP            = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic       vsync,
    input  logic       key_ack,
    output logic [2:0] cursor_col,
    output logic [1:0] cursor_row,
    output logic [9:0] cursor_x,
    output logic [9:0] cursor_y,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam logic WRAP_EN = (WRAP != 0);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;
    logic                unused_levels;

    assign btn_raw = {btn_sel, btn_up, btn_down, btn_left, btn_right};
    assign unused_levels = ^btn_level[BTN_UP:BTN_RIGHT];

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[i]),
            .level  (btn_level[i]),
            .press  (btn_press[i])
        );
    end

    logic [1:0] vs_sync_q, vs_sync_d;
    logic       vs_prev_q, vs_prev_d;
    logic       vs_fall;

    logic       sel_evt;
    logic       move_evt;
    move_dir_e  move_dir;

    logic       pend_valid_q, pend_valid_d;
    move_dir_e  pend_dir_q, pend_dir_d;
    logic [2:0] col_q, col_d;
    logic [1:0] row_q, row_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;

    sel_state_e state_q;
    logic       key_valid_q;
    logic [3:0] key_code_q;

    // Select wins outright; otherwise the highest-priority direction is kept.
    always_comb begin
        sel_evt  = btn_press[BTN_SEL];
        move_evt = !btn_press[BTN_SEL] && (|btn_press[BTN_UP:BTN_RIGHT]);
        if (btn_press[BTN_UP])
            move_dir = MOVE_UP;
        else if (btn_press[BTN_DOWN])
            move_dir = MOVE_DOWN;
        else if (btn_press[BTN_LEFT])
            move_dir = MOVE_LEFT;
        else
            move_dir = MOVE_RIGHT;
    end

    assign vs_sync_d = {vs_sync_q[0], vsync};
    assign vs_prev_d = vs_sync_q[1];
    assign vs_fall   = vs_prev_q && !vs_sync_q[1];

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        col_d        = col_q;
        row_d        = row_q;
        if (vs_fall) begin
            if (pend_valid_q) begin
                col_d = next_col(col_q, pend_dir_q, WRAP_EN);
                row_d = next_row(row_q, pend_dir_q, WRAP_EN);
            end
            pend_valid_d = 1'b0;
        end
        if (move_evt && (!pend_valid_q || vs_fall)) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = move_dir;
        end
        x_d = pixel_x(col_d);
        y_d = pixel_y(row_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync_q    <= 2'b11;
            vs_prev_q    <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= MOVE_UP;
            col_q        <= RESET_COL;
            row_q        <= RESET_ROW;
            x_q          <= pixel_x(RESET_COL);
            y_q          <= pixel_y(RESET_ROW);
        end else begin
            vs_sync_q    <= vs_sync_d;
            vs_prev_q    <= vs_prev_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            col_q        <= col_d;
            row_q        <= row_d;
            x_q          <= x_d;
            y_q          <= y_d;
        end
    end

    // Select handshake; key_code stays at the latched cell while the cursor moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEL_IDLE;
            key_valid_q <= 1'b0;
            key_code_q  <= RESET_KEY;
        end else begin
            case (state_q)
                SEL_IDLE: begin
                    if (sel_evt) begin
                        key_code_q  <= key_at(col_q, row_q);
                        key_valid_q <= 1'b1;
                        state_q     <= SEL_VALID;
                    end
                end
                SEL_VALID: begin
                    if (key_ack) begin
                        key_valid_q <= 1'b0;
                        state_q     <= btn_level[BTN_SEL] ? SEL_WAIT_REL : SEL_IDLE;
                    end
                end
                SEL_WAIT_REL: begin
                    if (!btn_level[BTN_SEL])
                        state_q <= SEL_IDLE;
                end
                default: begin
                    key_valid_q <= 1'b0;
                    state_q     <= SEL_IDLE;
                end
            endcase
        end
    end

    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign cursor_x   = x_q;
    assign cursor_y   = y_q;
    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;

endmodule

// File: tb/tb_keypad_cursor_ctrl.sv
// Bench for keypad_cursor_ctrl: a wrapping and a saturating instance share
// stimulus and are checked against an event-level grid/handshake model.
module tb_keypad_cursor_ctrl;

    logic clk;
    logic rst_n;
    logic btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic vsync;
    logic key_ack;

    logic [2:0] col   [2];
    logic [1:0] row   [2];
    logic [9:0] px    [2];
    logic [9:0] py    [2];
    logic [3:0] code  [2];
    logic       valid [2];

    int compared   = 0;
    int mismatched = 0;
    bit settle     = 1'b0;

    // Model state: index 0 is the wrapping DUT, index 1 the saturating one.
    int mCol[2], mRow[2], mValid[2], mCode[2], mState[2], mPend[2];
    int keyTable[15] = '{7, 8, 9, 10, 13, 4, 5, 6, 11, 12, 1, 2, 3, 0, 14};

    keypad_cursor_ctrl #(.DEBOUNCE_CYCLES(4), .WRAP(1)) dutWrap (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .vsync(vsync), .key_ack(key_ack),
        .cursor_col(col[0]), .cursor_row(row[0]),
        .cursor_x(px[0]), .cursor_y(py[0]),
        .key_code(code[0]), .key_valid(valid[0])
    );

    keypad_cursor_ctrl #(.DEBOUNCE_CYCLES(4), .WRAP(0)) dutSat (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .vsync(vsync), .key_ack(key_ack),
        .cursor_col(col[1]), .cursor_row(row[1]),
        .cursor_x(px[1]), .cursor_y(py[1]),
        .key_code(code[1]), .key_valid(valid[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mCol[d] = 2; mRow[d] = 1; mValid[d] = 0; mCode[d] = 5;
            mState[d] = 0; mPend[d] = -1;
        end
    endtask

    // mask bits: 4=sel 3=up 2=down 1=left 0=right
    task automatic modelPress(input logic [4:0] mask);
        int dir;
        for (int d = 0; d < 2; d++) begin
            if (mask[4]) begin
                if (mState[d] == 0) begin
                    mState[d] = 1;
                    mValid[d] = 1;
                    mCode[d]  = keyTable[mRow[d] * 5 + mCol[d]];
                end
            end else if (mask[3:0] != 4'b0) begin
                dir = mask[3] ? 0 : mask[2] ? 1 : mask[1] ? 2 : 3;
                if (mPend[d] < 0) mPend[d] = dir;
            end
        end
    endtask

    task automatic modelFrame();
        int c, r;
        for (int d = 0; d < 2; d++) begin
            if (mPend[d] >= 0) begin
                c = mCol[d]; r = mRow[d];
                case (mPend[d])
                    0: r = r - 1;
                    1: r = r + 1;
                    2: c = c - 1;
                    default: c = c + 1;
                endcase
                if (d == 0) begin
                    c = (c + 5) % 5;
                    r = (r + 3) % 3;
                end else begin
                    c = (c < 0) ? 0 : (c > 4) ? 4 : c;
                    r = (r < 0) ? 0 : (r > 2) ? 2 : r;
                end
                mCol[d] = c; mRow[d] = r; mPend[d] = -1;
            end
        end
    endtask

    task automatic modelAck(input bit selHeld);
        for (int d = 0; d < 2; d++)
            if (mValid[d] == 1) begin
                mValid[d] = 0;
                mState[d] = selHeld ? 2 : 0;
            end
    endtask

    task automatic modelSelRelease();
        for (int d = 0; d < 2; d++)
            if (mState[d] == 2) mState[d] = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n && !settle) begin
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("dut%0d col", d), col[d], mCol[d]);
                checkOutput($sformatf("dut%0d row", d), row[d], mRow[d]);
                checkOutput($sformatf("dut%0d x", d), px[d], 60 + 90 * mCol[d]);
                checkOutput($sformatf("dut%0d y", d), py[d], 160 + 100 * mRow[d]);
                checkOutput($sformatf("dut%0d key_valid", d), valid[d], mValid[d]);
                checkOutput($sformatf("dut%0d key_code", d), code[d], mCode[d]);
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] mask, input int hold);
        @(posedge clk); #2;
        if (mask[4]) settle = 1'b1;
        btn_sel = mask[4]; btn_up = mask[3]; btn_down = mask[2];
        btn_left = mask[1]; btn_right = mask[0];
        repeat (hold) @(posedge clk);
        #2;
        {btn_sel, btn_up, btn_down, btn_left, btn_right} = 5'b0;
        repeat (12) @(posedge clk);
        #2;
        if (hold >= 4) modelPress(mask);
        settle = 1'b0;
    endtask

    task automatic pulseVsync();
        @(posedge clk); #2;
        settle = 1'b1;
        vsync  = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        modelFrame();
        settle = 1'b0;
        vsync  = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic sendAck(input bit selHeld);
        @(posedge clk); #2;
        key_ack = 1'b1;
        @(posedge clk); #2;
        key_ack = 1'b0;
        modelAck(selHeld);
    endtask

    task automatic doReset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        modelReset();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        int hold;
        logic [4:0] mask;

        rst_n = 1'b0;
        {btn_sel, btn_up, btn_down, btn_left, btn_right} = 5'b0;
        vsync = 1'b1;
        key_ack = 1'b0;
        modelReset();
        doReset();
        @(posedge clk); #2;

        // Reset values
        checkOutput("reset col", col[0], 2);
        checkOutput("reset row", row[0], 1);
        checkOutput("reset x", px[0], 240);
        checkOutput("reset y", py[0], 260);
        checkOutput("reset key_valid", valid[1], 0);
        checkOutput("reset key_code", code[1], 5);

        // Move is held back until the frame boundary
        applyStimulus(5'b00001, 10);
        checkOutput("right pre-vsync x", px[0], 240);
        checkOutput("right pre-vsync col", col[0], 2);
        pulseVsync();
        checkOutput("right post-vsync col", col[0], 3);
        checkOutput("right post-vsync x", px[0], 330);

        // Glitch rejection and one move per frame
        applyStimulus(5'b01000, 3);
        pulseVsync();
        checkOutput("glitch row", row[0], 1);
        applyStimulus(5'b00001, 8);
        applyStimulus(5'b00001, 8);
        pulseVsync();
        checkOutput("double right col", col[0], 4);
        checkOutput("double right x", px[0], 420);

        // Edge behaviour with and without wrap
        applyStimulus(5'b00100, 8);
        pulseVsync();
        checkOutput("corner row", row[1], 2);
        checkOutput("corner y", py[1], 360);
        applyStimulus(5'b00001, 8);
        pulseVsync();
        applyStimulus(5'b00100, 8);
        pulseVsync();
        checkOutput("wrap col", col[0], 0);
        checkOutput("wrap row", row[0], 0);
        checkOutput("sat col", col[1], 4);
        checkOutput("sat row", row[1], 2);
        applyStimulus(5'b10000, 8);
        checkOutput("wrap sel code", code[0], 7);
        checkOutput("sat sel code", code[1], 14);
        checkOutput("wrap sel valid", valid[0], 1);
        sendAck(1'b0);
        checkOutput("ack valid", valid[0], 0);

        // Select on '+' with a long unacknowledged hold
        doReset();
        applyStimulus(5'b00001, 8);
        pulseVsync();
        applyStimulus(5'b01000, 8);
        pulseVsync();
        checkOutput("plus col", col[1], 3);
        checkOutput("plus row", row[1], 0);
        applyStimulus(5'b10000, 8);
        checkOutput("plus code", code[0], 10);
        checkOutput("plus valid", valid[0], 1);
        repeat (20) @(posedge clk);
        #2;
        checkOutput("plus held valid", valid[0], 1);
        applyStimulus(5'b10000, 8);
        checkOutput("second sel code", code[0], 10);
        checkOutput("second sel valid", valid[1], 1);
        @(posedge clk); #2;
        key_ack = 1'b1;
        checkOutput("valid during ack", valid[0], 1);
        @(posedge clk); #2;
        key_ack = 1'b0;
        modelAck(1'b0);
        checkOutput("valid after ack", valid[0], 0);
        repeat (20) @(posedge clk);
        #2;
        checkOutput("no repeat event", valid[0], 0);

        // Acknowledge while select is still held, then release
        settle = 1'b1;
        btn_sel = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        modelPress(5'b10000);
        settle = 1'b0;
        checkOutput("held sel valid", valid[0], 1);
        sendAck(1'b1);
        checkOutput("held sel ack valid", valid[0], 0);
        repeat (10) @(posedge clk);
        #2;
        btn_sel = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        modelSelRelease();
        checkOutput("release no event", valid[1], 0);
        sendAck(1'b0);
        checkOutput("idle ack code", code[0], 10);
        checkOutput("idle ack valid", valid[0], 0);

        // Select beats a simultaneous move; reset drops the handshake at once
        applyStimulus(5'b10010, 8);
        checkOutput("sel+left valid", valid[0], 1);
        pulseVsync();
        checkOutput("sel+left col", col[0], 3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset valid", valid[0], 0);
        checkOutput("async reset col", col[1], 2);
        repeat (3) @(posedge clk);
        #2;
        modelReset();
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        checkOutput("post reset valid", valid[0], 0);
        checkOutput("post reset code", code[0], 5);

        // Randomized mix of presses, glitches, frames and acknowledges
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                mask = 5'($urandom_range(1, 31));
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 10);
                applyStimulus(mask, hold);
            end else if (r < 8) begin
                pulseVsync();
            end else begin
                sendAck(1'b0);
            end
        end
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_cursor_ctrl.md
KEYPAD_CURSOR_CTRL -- requirements
Module: keypad_cursor_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning clk cycles an input must be stable before it is accepted (10 ms at 50 MHz).
REQ-002 SHALL have parameter WRAP, default 1, meaning 1 = cursor wraps at grid edges, 0 = cursor saturates.
REQ-003 SHALL have port clk  input  1  system clock, single clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_sel  input  1 each  raw, active-high, asynchronous pushbuttons.
REQ-006 SHALL have port vsync  input  1  active-low frame sync from the VGA sync unit.
REQ-007 SHALL have port key_ack  input  1  consumer acknowledge for key_valid.
REQ-008 SHALL have ports cursor_col  output  3 and cursor_row  output  2  current highlighted grid cell.
REQ-009 SHALL have ports cursor_x, cursor_y  output  10 each  top-left pixel origin of the highlighted key.
REQ-010 SHALL have ports key_code  output  4 and key_valid  output  1  selected key and its valid flag.

Function
REQ-011 SHALL model a 5-column x 3-row key grid: row0 = 7,8,9,+,/; row1 = 4,5,6,-,*; row2 = 1,2,3,0,=.
REQ-012 SHALL encode keys as follows: digits 0-9 = 0x0-0x9, + = 0xA, - = 0xB, * = 0xC, / = 0xD, = = 0xE; 0xF is never produced.
REQ-013 SHALL compute cursor_x = 60 + 90*cursor_col and cursor_y = 160 + 100*cursor_row, registered, updated in the same cycle as cursor_col/row.
REQ-014 SHALL pass each button through a 2-flop synchronizer and then a debouncer: accept a level change only after DEBOUNCE_CYCLES consecutive equal samples; the counter restarts on any mismatch.
REQ-015 SHALL generate a one-cycle press event on each debounced 0->1 transition; holding a button produces no further events (no auto-repeat).
REQ-016 SHALL resolve simultaneous press events by priority sel > up > down > left > right; lower-priority events in the same cycle are discarded.
REQ-017 SHALL latch at most one pending move per frame; further move events before it is applied are discarded.
REQ-018 SHALL apply the pending move on the cycle after a vsync falling edge (2-flop synchronized), so the cursor never changes mid-frame.
REQ-019 SHALL, with WRAP=1, wrap col 4->0 on right, 0->4 on left, row 2->0 on down, and 0->2 on up; with WRAP=0, it SHALL hold the cursor at the edge.
REQ-020 SHALL implement the select FSM with states IDLE, VALID, and WAIT_REL.
REQ-021 SHALL, in IDLE, on a sel event, latch key_code from the current cell, assert key_valid, and go to VALID.
REQ-022 SHALL, in VALID, hold key_valid and key_code stable until key_ack=1, then deassert key_valid next cycle; it SHALL go to WAIT_REL if debounced sel=1, else to IDLE.
REQ-023 SHALL, in WAIT_REL, return to IDLE once debounced sel=0.
REQ-024 SHALL ignore sel events outside IDLE, so no key is lost or duplicated.
REQ-025 SHALL keep processing move events in all FSM states; key_code remains the latched value, not the live cell.
REQ-026 SHALL treat key_ack while key_valid=0 as a no-op.

Reset
REQ-027 SHALL asynchronously, on rst_n=0, set cursor_col=2, cursor_row=1 (key 5), cursor_x=240, cursor_y=260, key_code=0x5, key_valid=0, FSM=IDLE, pending move cleared, debounce counters=0, debounced levels=0.
REQ-028 SHALL, when reset is asserted mid-handshake, drop key_valid immediately, and no key event SHALL be emitted after release until a new debounced sel press occurs.

Structure
REQ-029 SHALL place the grid dimensions (5, 3), origin/pitch constants (60, 160, 90, 100), the key-code constants, and the FSM state encoding in the shared package keypad_pkg.
REQ-030 SHALL instantiate one sub-module, btn_debounce (synchronizer + counter + rising-edge pulse), five times.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-031 SHALL cover: reset release -> cursor (2,1), xy (240,260), key_valid=0.
REQ-032 SHALL cover: right pressed for 10 cycles, then a vsync falling edge -> col=3, x=330 only after the edge, unchanged before it.
REQ-033 SHALL cover: 3-cycle glitch on btn_up -> no movement; right pressed twice within one frame -> col advances by exactly 1.
REQ-034 SHALL cover: cursor at (4,2), WRAP=1, right then down across two frames -> (0,0), code 0x7 on sel; same sequence with WRAP=0 -> stays at (4,2), code 0xE.
REQ-035 SHALL cover: sel on (3,0) -> key_valid=1, code 0xA, held 20 cycles without ack; second sel ignored; key_ack -> key_valid=0 next cycle, no second event.
REQ-036 SHALL cover: sel and left asserted in the same cycle -> select only, no move; rst_n low while VALID -> key_valid=0 asynchronously.
